// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MAXNET winner-take-all engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxnet_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default ROM image for the 4 x 32-bit configuration.
    // Entry i sits at bits [i*32 +: 32].
    localparam logic [4*32-1:0] ROM_DEFAULT = {
        32'h0000_0500,   // index 3
        32'h0000_0F00,   // index 2
        32'h0000_1400,   // index 1
        32'h0000_0A00    // index 0
    };

    // Index width, at least one bit so N=2 still gets a real counter.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Activation width: one extra bit above the data width acts as the sign,
    // so the whole unsigned input range fits without wrapping.
    function automatic int act_width(input int w);
        return w + 1;
    endfunction

    // Width of the sum of N-1 activations with margin.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/maxnet_rom.sv
// Combinational N x W lookup table holding the neuron input values.
// Latency: 0 cycles (pure combinational read).
// Backpressure: none; data follows addr in the same cycle.
module maxnet_rom
    import maxnet_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int AW = 2,
    parameter logic [N*W-1:0] DATA = ROM_DEFAULT
) (
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  data
);

    // Mux the addressed word out of the flattened image; out-of-range reads zero.
    always_comb begin
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (addr == AW'(i)) begin
                data = DATA[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/maxnet_top.sv
// MAXNET engine: loads N ROM words, runs parallel lateral inhibition, reports winner.
// Latency: 1 + N + iterations + 1 cycles from the start edge to done.
// Backpressure: none; start edges are ignored while loading or iterating.
module maxnet_top
    import maxnet_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int EPS_SHIFT = 3,
    parameter logic [N*W-1:0] ROM_DATA = ROM_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] maxnumber,
    output logic         done
);

    localparam int IW  = idx_width(N);
    localparam int AWA = act_width(W);
    localparam int SW  = sum_width(N, W);
    localparam int CW  = $clog2(N + 1);

    state_t           state_q, state_d;
    logic             start_q;
    logic             trigger;
    logic [IW-1:0]    idx_q;
    logic [W-1:0]     rom_data;
    logic [W-1:0]     orig_q   [N];
    // Top bit is the sign; updates are clamped at zero so it stays clear.
    logic [AWA-1:0]   act_q    [N];
    logic [AWA-1:0]   act_nxt  [N];
    logic [SW-1:0]    sum_j    [N];
    logic [SW-1:0]    dec_j    [N];
    logic [N-1:0]     nz_mask;
    logic [N-1:0]     prev_nz_q;
    logic [N-1:0]     pick_mask;
    logic [CW-1:0]    nz_cnt;
    logic             term;
    logic             found;
    logic [IW-1:0]    winner;

    assign trigger = start & ~start_q;

    maxnet_rom #(
        .N    (N),
        .W    (W),
        .AW   (IW),
        .DATA (ROM_DATA)
    ) u_rom (
        .addr (idx_q),
        .data (rom_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a run is IDLE/DONE -> LOAD -> ITER -> DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (trigger) state_d = LOAD;
            LOAD: if (idx_q == IW'(N - 1)) state_d = ITER;
            ITER: if (term) state_d = DONE;
            DONE: if (trigger) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Parallel inhibition: every neuron subtracts eps times the sum of the others,
    // using the old activations, with a minimum step of 1 so small values still die.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            sum_j[j] = '0;
            for (int k = 0; k < N; k++) begin
                if (k != j) begin
                    sum_j[j] = sum_j[j] + SW'(act_q[k]);
                end
            end
            dec_j[j] = sum_j[j] >> EPS_SHIFT;
            if (sum_j[j] != '0 && dec_j[j] == '0) begin
                dec_j[j] = SW'(1);
            end
            if (dec_j[j] > SW'(act_q[j])) begin
                act_nxt[j] = '0;
            end else begin
                act_nxt[j] = AWA'(SW'(act_q[j]) - dec_j[j]);
            end
        end
    end

    // Termination and winner selection on the current activations. When the
    // last survivors all hit zero together, fall back to last cycle's mask.
    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < N; i++) begin
            nz_mask[i] = (act_q[i] != '0);
            nz_cnt     = nz_cnt + CW'(nz_mask[i]);
        end
        term      = (nz_cnt <= CW'(1));
        pick_mask = (nz_cnt != '0) ? nz_mask : prev_nz_q;
        winner    = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && pick_mask[i]) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
    end

    // Datapath registers: edge detect, load sequencing, activation updates, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            idx_q     <= '0;
            prev_nz_q <= '0;
            maxnumber <= '0;
            done      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                orig_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            start_q <= start;
            case (state_q)
                IDLE, DONE: begin
                    if (trigger) begin
                        idx_q     <= '0;
                        prev_nz_q <= '0;
                        done      <= 1'b0;
                    end
                end
                LOAD: begin
                    orig_q[idx_q] <= rom_data;
                    act_q[idx_q]  <= {1'b0, rom_data};
                    idx_q         <= idx_q + IW'(1);
                end
                ITER: begin
                    if (term) begin
                        maxnumber <= orig_q[winner];
                        done      <= 1'b1;
                    end else begin
                        prev_nz_q <= nz_mask;
                        for (int i = 0; i < N; i++) begin
                            act_q[i] <= act_nxt[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_top.sv
// Directed bench: five engine instances with different ROM images share clk/rst.
// Latency: checks exact start-to-done cycle counts where they are hand-derived.
// Backpressure: n/a.
module tb_maxnet_top;

    logic        clk;
    logic        rst;
    logic [4:0]  start_v;
    logic [4:0]  done_v;
    logic [31:0] mx_v [5];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 0: default image
    maxnet_top u0 (.clk(clk), .rst(rst), .start(start_v[0]), .maxnumber(mx_v[0]), .done(done_v[0]));
    // 1: {5,4,0,0} exercises the minimum-step fallback
    maxnet_top #(.ROM_DATA({32'd0, 32'd0, 32'd4, 32'd5}))
        u1 (.clk(clk), .rst(rst), .start(start_v[1]), .maxnumber(mx_v[1]), .done(done_v[1]));
    // 2: {7,7,3,0} tie between indices 0 and 1
    maxnet_top #(.ROM_DATA({32'd0, 32'd3, 32'd7, 32'd7}))
        u2 (.clk(clk), .rst(rst), .start(start_v[2]), .maxnumber(mx_v[2]), .done(done_v[2]));
    // 3: all zero
    maxnet_top #(.ROM_DATA({32'd0, 32'd0, 32'd0, 32'd0}))
        u3 (.clk(clk), .rst(rst), .start(start_v[3]), .maxnumber(mx_v[3]), .done(done_v[3]));
    // 4: {FFFFFFFF,1,2,3} full-range value
    maxnet_top #(.ROM_DATA({32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF}))
        u4 (.clk(clk), .rst(rst), .start(start_v[4]), .maxnumber(mx_v[4]), .done(done_v[4]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise start on instance i and count clock edges until done is seen.
    // start is left high; the caller decides when to drop it.
    task automatic run(input int i, input int budget, output int lat);
        @(negedge clk);
        start_v[i] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done_v[i] && lat < budget);
        check($sformatf("done_reached_%0d", i), {63'd0, done_v[i]}, 64'd1);
    endtask

    task automatic drop(input int i);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    int lat;

    initial begin
        rst     = 1'b1;
        start_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_done_%0d", i), {63'd0, done_v[i]}, 64'd0);
            check($sformatf("reset_max_%0d", i), {32'd0, mx_v[i]}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Default image, start held for 10 cycles: a single run, winner 0x1400.
        @(negedge clk);
        start_v[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 0;
        while (!done_v[0] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t1_done", {63'd0, done_v[0]}, 64'd1);
        check("t1_max", {32'd0, mx_v[0]}, 64'h1400);
        repeat (10) @(posedge clk);
        #1;
        check("t1_done_holds", {63'd0, done_v[0]}, 64'd1);

        // {5,4,0,0}: four updates -> latency 1+4+4+1; start held through DONE.
        run(1, 300, lat);
        check("t2_latency", 64'(lat), 64'd10);
        check("t2_max", {32'd0, mx_v[1]}, 64'd5);
        repeat (6) @(posedge clk);
        #1;
        check("t2_held_start_no_rerun", {63'd0, done_v[1]}, 64'd1);
        drop(1);

        // {7,7,3,0}: seven updates, indices 0 and 1 hit zero together.
        run(2, 300, lat);
        drop(2);
        check("t3_latency", 64'(lat), 64'd13);
        check("t3_max", {32'd0, mx_v[2]}, 64'd7);

        // All zero: no updates, latency 1+4+1.
        run(3, 300, lat);
        drop(3);
        check("t4_latency", 64'(lat), 64'd6);
        check("t4_max", {32'd0, mx_v[3]}, 64'd0);

        // Full-range input: one update, latency 1+4+1+1.
        run(4, 300, lat);
        drop(4);
        check("t5_latency", 64'(lat), 64'd7);
        check("t5_max", {32'd0, mx_v[4]}, 64'hFFFF_FFFF);

        // Second start edge after done: done drops, old result held, then re-asserts.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("t6_done_drops", {63'd0, done_v[0]}, 64'd0);
        check("t6_max_held", {32'd0, mx_v[0]}, 64'h1400);
        lat = 1;
        while (!done_v[0] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t6_rerun_done", {63'd0, done_v[0]}, 64'd1);
        check("t6_rerun_max", {32'd0, mx_v[0]}, 64'h1400);
        drop(0);

        // Reset in the middle of iterating, then a clean rerun.
        @(negedge clk);
        start_v[0] = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t7_rst_done", {63'd0, done_v[0]}, 64'd0);
        check("t7_rst_max", {32'd0, mx_v[0]}, 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        run(0, 300, lat);
        drop(0);
        check("t7_rerun_max", {32'd0, mx_v[0]}, 64'h1400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
